line_buffer_v3_fp16: RTL

Vertical window generator for the DFDD box-filter path. It takes a raster-order fp16 pixel stream and produces 3×1 vertical windows centred on each pixel, one window per cycle. Windows go to the vertical box convolution stage that sits directly downstream. It holds two line buffers, pads the top and bottom image borders, and flushes the last image row after the frame's final pixel.

---
 rtl/line_buffer_v3_fp16_if.sv | 34 +++
 rtl/line_buffer_v3_fp16.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/line_buffer_v3_fp16_if.sv
// ---------------------------------------------------------------------------
// line_buffer_v3_fp16_if
// Bundles the pixel-stream input and the window output of line_buffer_v3_fp16.
//   data_i/col_i/row_i/valid_i : incoming raster-order fp16 pixel and its position
//   ready_o                    : block accepts input (pixel taken on valid_i && ready_o)
//   window_o                   : 3x1 vertical window, [0] = row above, [2] = row below
//   col_o/row_o/valid_o        : centre position of the window and its valid flag
// Modports: slave = the line buffer, master = the upstream/downstream side.
// ---------------------------------------------------------------------------
interface line_buffer_v3_fp16_if #(
  parameter int FP_WIDTH_REG  = 16,
  parameter int WINDOW_HEIGHT = 3,
  parameter int WINDOW_WIDTH  = 1
);
  logic [FP_WIDTH_REG-1:0] data_i;
  logic [15:0]             col_i;
  logic [15:0]             row_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [15:0]             col_o;
  logic [15:0]             row_o;
  logic                    valid_o;

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/line_buffer_v3_fp16.sv
// ---------------------------------------------------------------------------
// line_buffer_v3_fp16
// Vertical 3x1 window generator for a raster-order fp16 pixel stream.
// Two line buffers hold the previous two rows; each accepted pixel of row R
// emits the window centred on (c, R-1). After the last pixel of the frame the
// block stalls input and flushes the last row with a bottom pad.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-low reset
//   bus   : line_buffer_v3_fp16_if.slave (pixel input, window output, ready)
// Configuration macro: LINE_BUFFER_V3_REPLICATE_EN
//   defined   -> border slots replicate the centre pixel
//   undefined -> border slots are +0.0
// ---------------------------------------------------------------------------
module line_buffer_v3_fp16 #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int WINDOW_HEIGHT = 3,
  parameter int WINDOW_WIDTH  = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  line_buffer_v3_fp16_if.slave bus
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [15:0]   W16      = 16'(IMAGE_WIDTH);
  localparam logic [15:0]   H16      = 16'(IMAGE_HEIGHT);
  localparam logic [AW-1:0] LAST_COL = AW'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           flush_cnt_q, flush_cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [FP_WIDTH_REG-1:0] win_q [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [FP_WIDTH_REG-1:0] win_d [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [15:0]             col_q, col_d;
  logic [15:0]             row_q, row_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before it. Not reset.
  logic [FP_WIDTH_REG-1:0] lb0_mem [IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] lb1_mem [IMAGE_WIDTH];

  logic                    in_range, accept, first_pixel, last_pixel, lb_we;
  logic [AW-1:0]           wr_addr, rd_addr;
  logic [FP_WIDTH_REG-1:0] lb0_rd, lb1_rd, pad_top, pad_bot;

  always_comb begin
    in_range    = (bus.col_i < W16) && (bus.row_i < H16);
    accept      = bus.valid_i && ready_q && in_range;
    first_pixel = (bus.col_i == 16'd0) && (bus.row_i == 16'd0);
    last_pixel  = (bus.col_i == W16 - 16'd1) && (bus.row_i == H16 - 16'd1);
    wr_addr     = bus.col_i[AW-1:0];
    // In FLUSH the buffers are walked by the internal counter instead of col_i.
    rd_addr     = (state_q == FLUSH) ? flush_cnt_q : wr_addr;
    lb0_rd      = lb0_mem[rd_addr];
    lb1_rd      = lb1_mem[rd_addr];
    // In IDLE only the frame's first pixel is stored; everything else is dropped.
    lb_we       = accept && ((state_q == STREAM) || ((state_q == IDLE) && first_pixel));
`ifdef LINE_BUFFER_V3_REPLICATE_EN
    // The centre pixel of the window always comes from lb0 at the read address.
    pad_top     = lb0_rd;
    pad_bot     = lb0_rd;
`else
    pad_top     = '0;
    pad_bot     = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    valid_d     = 1'b0;
    win_d       = win_q;
    col_d       = col_q;
    row_d       = row_q;
    case (state_q)
      IDLE: begin
        if (lb_we) state_d = STREAM;
      end
      STREAM: begin
        if (lb_we) begin
          if (bus.row_i != 16'd0) begin
            win_d[0][0] = (bus.row_i == 16'd1) ? pad_top : lb1_rd;
            win_d[1][0] = lb0_rd;
            win_d[2][0] = bus.data_i;
            col_d       = bus.col_i;
            row_d       = bus.row_i - 16'd1;
            valid_d     = 1'b1;
          end
          if (last_pixel) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        win_d[0][0] = lb1_rd;
        win_d[1][0] = lb0_rd;
        win_d[2][0] = pad_bot;
        col_d       = 16'(flush_cnt_q);
        row_d       = H16 - 16'd1;
        valid_d     = 1'b1;
        if (flush_cnt_q == LAST_COL) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low for exactly the cycles spent in FLUSH.
    ready_d = (state_d != FLUSH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      for (int i = 0; i < WINDOW_HEIGHT; i++)
        for (int j = 0; j < WINDOW_WIDTH; j++)
          win_q[i][j] <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
    end
  end

  // Shift the column down one row: old lb0 moves to lb1, new pixel lands in lb0.
  always_ff @(posedge clk_i) begin
    if (lb_we) begin
      lb1_mem[wr_addr] <= lb0_rd;
      lb0_mem[wr_addr] <= bus.data_i;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.window_o = win_q;
  assign bus.col_o    = col_q;
  assign bus.row_o    = row_q;

endmodule
